denoise_window_sequencer: RTL and testbench

- Streaming controller that sequences the NxN colour-mask denoise datapath.
- Accepts a raster stream of colour-masked pixels (bit COLORS = valid, bits COLORS-1:0 = colour flags) and maintains N_SIZE-1 line buffers plus an NxN window register.
- Inserts edge-padding cycles and presents one NxN window per image pixel, with centre coordinates, to the denoise datapath.
- Sits between the colour-mask stage and the denoise stage.

---
 rtl/denoise_window_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_denoise_window_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/denoise_window_sequencer.sv
// Raster-to-window sequencer for the NxN colour-mask denoise stage. It keeps the line
// buffers, inserts edge padding and presents one coordinate-masked window per pixel.
//
// state  | meaning
// S_IDLE | waiting for a start-of-frame beat; beats without in_sof are dropped
// S_RUN  | scanning the virtual raster (image plus H padding rows and columns)
module denoise_window_sequencer #(
  parameter int N_SIZE = 5,
  parameter int COLORS = 2,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [COLORS:0]                          in_pixel,
  input  logic                                     in_valid,
  input  logic                                     in_sof,
  output logic                                     in_ready,
  output logic [0:N_SIZE-1][0:N_SIZE-1][COLORS:0]  win_out,
  output logic                                     win_valid,
  output logic [$clog2(IMG_H)-1:0]                 win_row,
  output logic [$clog2(IMG_W)-1:0]                 win_col,
  output logic                                     frame_done,
  output logic                                     frame_err
);

  localparam int H   = N_SIZE / 2;
  localparam int PW  = COLORS + 1;
  localparam int NLB = N_SIZE - 1;
  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int VRW = $clog2(IMG_H + H);
  localparam int VCW = $clog2(IMG_W + H);

  localparam logic [VRW-1:0] VR_LAST = VRW'(IMG_H + H - 1);
  localparam logic [VCW-1:0] VC_LAST = VCW'(IMG_W + H - 1);
  localparam logic [VRW-1:0] VR_IMG  = VRW'(IMG_H);
  localparam logic [VCW-1:0] VC_IMG  = VCW'(IMG_W);
  localparam logic [VRW-1:0] HR      = VRW'(H);
  localparam logic [VCW-1:0] HC      = VCW'(H);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef logic [0:N_SIZE-1][0:N_SIZE-1][PW-1:0] win_t;

  state_t           state_q, state_d;
  logic [VRW-1:0]   vr_q, vr_d;
  logic [VCW-1:0]   vc_q, vc_d;
  win_t             win_q, win_d;
  logic             in_ready_q, in_ready_d;
  logic             win_valid_q, win_valid_d;
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  logic                           accept, sof_acc, proc, p_real, col_ok;
  logic [VRW-1:0]                 p_r;
  logic [VCW-1:0]                 p_c;
  logic [PW-1:0]                  cur_pix;
  logic [0:N_SIZE-1][PW-1:0]      new_col;
  logic                           lb_we;
  logic [CW-1:0]                  lb_addr;
  logic [PW-1:0]                  lb_rd [0:NLB-1];
  logic [PW-1:0]                  lb_q  [0:NLB-1][0:IMG_W-1];

  // An accepted start-of-frame beat always becomes position (0,0), even mid-frame.
  always_comb begin
    accept  = in_valid && in_ready_q;
    sof_acc = accept && in_sof;
    p_r     = sof_acc ? '0 : vr_q;
    p_c     = sof_acc ? '0 : vc_q;
    p_real  = (p_r < VR_IMG) && (p_c < VC_IMG);
    col_ok  = (p_c < VC_IMG);
    proc    = sof_acc || ((state_q == S_RUN) && (!p_real || accept));
    cur_pix = p_real ? in_pixel : '0;
    lb_addr = p_c[CW-1:0];
    lb_we   = proc && col_ok;
  end

  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      lb_rd[k] = lb_q[k][lb_addr];
    end
  end

  // Window rows whose image row lies outside the frame are zeroed, which hides stale buffer rows.
  always_comb begin
    new_col = '0;
    for (int j = 0; j < N_SIZE - 1; j++) begin
      new_col[j] = lb_rd[N_SIZE-2-j];
      if (!col_ok || (p_r < VRW'(N_SIZE-1-j)) || ((p_r - VRW'(N_SIZE-1-j)) >= VR_IMG)) begin
        new_col[j] = '0;
      end
    end
    new_col[N_SIZE-1] = cur_pix;
  end

  always_comb begin
    state_d      = state_q;
    vr_d         = vr_q;
    vc_d         = vc_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;
    frame_err_d  = sof_acc && (state_q == S_RUN);

    if (proc) begin
      for (int j = 0; j < N_SIZE; j++) begin
        for (int i = 0; i < N_SIZE - 1; i++) begin
          win_d[j][i] = win_q[j][i+1];
        end
        win_d[j][N_SIZE-1] = new_col[j];
      end

      win_valid_d = (p_r >= HR) && (p_c >= HC);
      win_row_d   = RW'(p_r - HR);
      win_col_d   = CW'(p_c - HC);

      if (p_c == VC_LAST) begin
        vc_d = '0;
        if (p_r == VR_LAST) begin
          vr_d         = '0;
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          vr_d    = p_r + 1'b1;
          state_d = S_RUN;
        end
      end else begin
        vc_d    = p_c + 1'b1;
        vr_d    = p_r;
        state_d = S_RUN;
      end
    end

    in_ready_d = (state_d == S_IDLE) || ((vr_d < VR_IMG) && (vc_d < VC_IMG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vr_q         <= '0;
      vc_q         <= '0;
      win_q        <= '0;
      in_ready_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vr_q         <= vr_d;
      vc_q         <= vc_d;
      win_q        <= win_d;
      in_ready_q   <= in_ready_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Buffer contents need no reset: every read is masked by image coordinates.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[0][lb_addr] <= cur_pix;
      for (int k = 1; k < NLB; k++) begin
        lb_q[k][lb_addr] <= lb_rd[k-1];
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_denoise_window_sequencer.sv
// Bench for denoise_window_sequencer: cycle table for the frame start, then randomized
// frames compared against a per-frame window model built from the received image.
`timescale 1ns/1ps
module tb_denoise_window_sequencer;
  localparam int N   = 3;
  localparam int C   = 2;
  localparam int W   = 8;
  localparam int HT  = 6;
  localparam int HH  = N / 2;
  localparam int RW  = $clog2(HT);
  localparam int CWD = $clog2(W);
  localparam int NB  = HT * W;

  typedef logic [0:N-1][0:N-1][C:0] win_t;
  typedef struct { int row; int col; win_t win; bit done; } wrec_t;
  typedef struct { bit v; bit sof; bit rdy; bit wv; int row; int col; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [C:0] in_pixel = '0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic in_ready;
  win_t win_out;
  logic win_valid;
  logic [RW-1:0] win_row;
  logic [CWD-1:0] win_col;
  logic frame_done, frame_err;

  denoise_window_sequencer #(.N_SIZE(N), .COLORS(C), .IMG_W(W), .IMG_H(HT)) dut (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .win_out(win_out), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: collects windows and pulses, and checks that an idle real position yields no window.
  wrec_t got_q[$];
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, first_cyc = 0;
  bit idle_real = 0;
  always @(negedge clk) idle_real = rst_n && in_ready && !in_valid;
  always begin
    @(posedge clk);
    #2;
    if (idle_real) chk("no_window_on_idle", win_valid, 1'b0);
    if (win_valid) begin
      if (got_q.size() == 0) first_cyc = cyc;
      got_q.push_back('{int'(win_row), int'(win_col), win_out, frame_done});
    end
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (frame_err) begin err_cnt++; err_cyc = cyc; end
  end

  // Reference model: windows a frame yields when only its first nbeats beats arrive.
  logic [C:0] img [HT][W];
  wrec_t exp_q[$];
  task automatic model_frame(input int nbeats);
    int used = 0;
    for (int r = 0; r < HT + HH; r++) begin
      for (int c = 0; c < W + HH; c++) begin
        if (r < HT && c < W) begin
          if (used == nbeats) return;
          used++;
        end
        if (r >= HH && c >= HH) begin
          wrec_t e;
          e.row = r - HH;
          e.col = c - HH;
          e.done = (r == HT + HH - 1) && (c == W + HH - 1);
          e.win = '0;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              int rr = e.row - HH + i;
              int cc = e.col - HH + j;
              if (rr >= 0 && rr < HT && cc >= 0 && cc < W && (rr * W + cc) < nbeats)
                e.win[i][j] = img[rr][cc];
            end
          end
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_window_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      chk($sformatf("%s_row%0d", tag, k), got_q[k].row, exp_q[k].row);
      chk($sformatf("%s_col%0d", tag, k), got_q[k].col, exp_q[k].col);
      chk($sformatf("%s_win%0d", tag, k), got_q[k].win, exp_q[k].win);
      chk($sformatf("%s_done%0d", tag, k), got_q[k].done, exp_q[k].done);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  // Driver: called and returns at posedge+1; records acceptance cycle and stall count.
  int acc_cyc, last_stall;
  int beat_cyc [NB];
  int beat_stall [NB];
  task automatic send_beat(input logic [C:0] px, input bit sof, input int gap);
    int g = 0;
    bit rdy;
    while (gap > 0 && g < 6 && $urandom_range(99, 0) < gap) begin
      in_valid = 1'b0; in_sof = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b1; in_sof = sof; in_pixel = px;
    last_stall = 0;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      last_stall++;
      if (last_stall > 40) begin chk("beat_accept_timeout", 0, 1); break; end
    end
    acc_cyc = cyc;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_range(input int b0, input int b1, input bit sof_first, input int gap);
    for (int b = b0; b < b1; b++) begin
      send_beat(img[b / W][b % W], sof_first && (b == b0), gap);
      beat_cyc[b] = acc_cyc;
      beat_stall[b] = last_stall;
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin @(posedge clk); #3; n++; end
    chk("frame_done_seen", done_cnt >= target, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  vec_t tv [18];
  int trail;

  initial begin
    for (int k = 0; k < 18; k++) tv[k] = '{1, 0, 1, 0, 0, 0};
    tv[5].sof = 1;
    tv[13].rdy = 0;
    tv[15] = '{1, 0, 1, 1, 0, 0};
    tv[16] = '{0, 0, 1, 0, 0, 0};
    tv[17] = '{1, 0, 1, 1, 0, 1};

    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_win_out", win_out, '0);
    chk("rst_win_row", win_row, '0);
    chk("rst_win_col", win_col, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle drops, start of frame, first padding cycle and first windows
    for (int k = 0; k < 18; k++) begin
      in_valid = tv[k].v; in_sof = tv[k].sof; in_pixel = 3'b101;
      @(negedge clk);
      chk($sformatf("tv%0d_in_ready", k), in_ready, tv[k].rdy);
      @(posedge clk); #1;
      chk($sformatf("tv%0d_win_valid", k), win_valid, tv[k].wv);
      if (tv[k].wv) begin
        chk($sformatf("tv%0d_win_row", k), win_row, tv[k].row);
        chk($sformatf("tv%0d_win_col", k), win_col, tv[k].col);
      end
    end

    // Asynchronous reset mid-frame while a window is on the outputs
    in_valid = 1'b0; in_sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_win_valid", win_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_win_out", win_out, '0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame after reset with an all-zero first row: no residue may show
    clear_mon();
    for (int r = 0; r < HT; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r == 0) ? '0 : 3'($urandom_range(7, 0));
    model_frame(NB);
    send_range(0, NB, 1'b1, 0);
    wait_done(1);
    compare_stream("post_reset");

    // Gapless constant frame: timing of ready, first window and frame length
    clear_mon();
    for (int r = 0; r < HT; r++)
      for (int c = 0; c < W; c++) img[r][c] = 3'b101;
    model_frame(NB);
    send_range(0, NB, 1'b1, 0);
    trail = 0;
    forever begin
      @(negedge clk);
      if (in_ready || trail > 50) break;
      trail++;
    end
    @(posedge clk); #1;
    wait_done(1);
    chk("trailing_ready_low", trail, HH + HH * (W + HH));
    for (int b = 0; b < NB; b++)
      chk($sformatf("stall_beat%0d", b), beat_stall[b], (b % W == 0 && b > 0) ? HH : 0);
    chk("first_window_cycle", first_cyc, beat_cyc[HH * W + HH]);
    chk("frame_cycles", done_cyc - beat_cyc[0] + 1, (HT + HH) * (W + HH));
    chk("gapless_done_count", done_cnt, 1);
    chk("gapless_err_count", err_cnt, 0);
    compare_stream("gapless");

    // Random gaps with random pixel patterns
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      for (int r = 0; r < HT; r++)
        for (int c = 0; c < W; c++) img[r][c] = 3'($urandom_range(7, 0));
      model_frame(NB);
      send_range(0, NB, 1'b1, 50);
      wait_done(1);
      chk($sformatf("gappy%0d_err_count", f), err_cnt, 0);
      compare_stream($sformatf("gappy%0d", f));
    end

    // Start-of-frame on beat 20 abandons frame A
    clear_mon();
    for (int r = 0; r < HT; r++)
      for (int c = 0; c < W; c++) img[r][c] = 3'($urandom_range(7, 0));
    model_frame(20);
    send_range(0, 20, 1'b1, 20);
    for (int r = 0; r < HT; r++)
      for (int c = 0; c < W; c++) img[r][c] = 3'($urandom_range(7, 0));
    model_frame(NB);
    send_range(0, NB, 1'b1, 20);
    wait_done(1);
    chk("restart_err_count", err_cnt, 1);
    chk("restart_err_cycle", err_cyc, beat_cyc[0]);
    chk("restart_done_count", done_cnt, 1);
    compare_stream("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
